board_io_ctrl: RTL
==================

# board_io_ctrl

Parametrised board I/O peripheral for the LOTR FPGA top level, replacing the tied-off HEX/LED/SW/BUTTON wiring with a live, register-mapped block. Cores reach it through a single-cycle register port. It drives seven-segment digits and LEDs, with optional blinking. It also presents synchronised switches and debounced buttons with sticky press flags.

## Interface
- NUM_HEX, default 6: seven-segment digits, 1..8.
- NUM_LED, default 10: LEDs, 1..32.
- NUM_SW, default 4: slide switches, 1..32.
- NUM_BTN, default 2: push buttons, 1..32; raw level 0 = pressed.
- DEBOUNCE_CYCLES, default 500000: cycles of stable input before the debounced state changes; ≥2.
- BLINK_CYCLES, default 12500000: half-period of the LED blink phase; ≥2.
- QClk  in  1  sole clock.
- RstQnnnH  in  1  reset, asynchronous, active-low.
- Addr  in  5  byte address, bits [1:0] ignored.
- WrEn  in  1  write strobe.
- RdEn  in  1  read strobe.
- WrData  in  32  write data.
- RdData  out  32  read data, registered.
- Sw  in  NUM_SW  raw switches, asynchronous.
- Btn  in  NUM_BTN  raw buttons, asynchronous, active-low.
- Hex  out  7*NUM_HEX  segments, digit d at [7d+6:7d], active-low, bit0 = seg a.
- Led  out  NUM_LED  LEDs, active-high.

## Operation
- Register map (word offsets):
  - 0x00 HEX_VAL rw: nibble d drives digit d; bits above 4*NUM_HEX read 0.
  - 0x04 HEX_EN rw: [NUM_HEX-1:0]. A digit whose bit is 0 is blanked (7'h7F).
  - 0x08 LED rw.
  - 0x0C SW ro.
  - 0x10 BTN_LVL ro: debounced pressed state, 1 = pressed.
  - 0x14 BTN_PRESS w1c: sticky press flags.
  - 0x18 LED_BLINK rw: per-LED blink enable.
- Writes to 0x0C and 0x10 are ignored. Unmapped addresses read 0; writes to them are ignored.
- Register widths: each rw register holds only its parameter width. Unused bits are written as don't-care and read 0.
- Input sync: Sw and Btn each pass through 2 flops.
- Debounce (per button): a counter runs while the synchronised level differs from the debounced state. On a match, the counter clears. When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced state flips and the counter clears.
- Press flag: set on a debounced released→pressed transition. A w1c write with the bit set clears the flag. If set and clear occur in the same cycle, set wins.
- Hex decode: standard 0-F glyphs, active-low. 0→7'h40, 1→7'h79, 8→7'h00, A→7'h08, F→7'h0E.
- Blink: a free-running prescaler toggles a phase bit every BLINK_CYCLES cycles. Led = LED & ~(LED_BLINK & {NUM_LED{phase}}).
- WrEn and RdEn asserted together: the write takes effect, and the read returns the pre-write value.

## Timing
- Reset values, all asynchronous:
  - Register group: HEX_VAL 0, HEX_EN 0, LED 0, LED_BLINK 0, BTN_PRESS 0, RdData 0, blink phase 0, counters 0.
  - Synchroniser group: Sw flops reset to 0. Btn flops reset to 1 (released). Debounced state resets to released.
  - Outputs in reset: Hex all 7'h7F, Led 0.
- Write: a register updates at the QClk edge where WrEn is sampled. Hex/Led change at that same edge; the decode is combinational from registers.
- Read: RdData is valid 1 cycle after RdEn. RdData holds its value when RdEn is low.
- SW latency: a raw change is readable in the SW register 2 edges later.
- Button latency: a press held stable is pressed in BTN_LVL 2+DEBOUNCE_CYCLES edges after the raw edge. The press flag sets on the same edge.
- Glitch rule: a glitch shorter than DEBOUNCE_CYCLES never changes debounced state.
- Reset mid-debounce: the counter is discarded, and the button reads released after reset even if held. A held button then registers a press DEBOUNCE_CYCLES+2 cycles after reset release.
- Counter width: $clog2 of the parameter. The counter must not wrap before reaching its terminal value.

## Test plan
- Reset, then write HEX_EN=0x3F and HEX_VAL=0x0018AF → Hex digits 0..5 = 7'h0E, 7'h08, 7'h00, 7'h79, 7'h40, 7'h40. HEX_EN=0x01 → digits 1..5 = 7'h7F.
- DEBOUNCE_CYCLES=8: drive Btn[0]=0 for 5 cycles, then 1 → BTN_LVL stays 0 and BTN_PRESS stays 0. Hold 0 for 12 cycles → BTN_LVL[0]=1 at edge 10 and BTN_PRESS[0]=1.
- With BTN_PRESS[0]=1, write 0x14 with 0x1 → reads 0. Repeat with a new press landing in the write cycle → reads 1.
- BLINK_CYCLES=4, LED=0x3FF, LED_BLINK=0x00F → Led alternates 0x3FF / 0x3F0 every 4 cycles.
- Sw=4'b1010 applied → RdData of read 0x0C equals 0xA from the third edge onward. A read of 0x1C returns 0. A write to 0x0C leaves the value unchanged.
- Assert RstQnnnH low mid-debounce with Btn held → Hex=7'h7F, Led=0, RdData=0 immediately. After release, the press is detected DEBOUNCE_CYCLES+2 cycles later.

Source files
------------

// File: rtl/board_io_ctrl_if.sv
// Single-cycle register port used by cores to reach board_io_ctrl.
interface board_io_ctrl_if;
  logic [4:0]  Addr;
  logic        WrEn;
  logic        RdEn;
  logic [31:0] WrData;
  logic [31:0] RdData;

  modport master (output Addr, WrEn, RdEn, WrData, input RdData);
  modport slave  (input Addr, WrEn, RdEn, WrData, output RdData);
endinterface

// File: rtl/board_io_ctrl.sv
// Register-mapped board I/O: seven-segment digits, LEDs with blink, synchronised
// switches and debounced buttons with sticky press flags.
module board_io_ctrl #(
  parameter int NUM_HEX         = 6,
  parameter int NUM_LED         = 10,
  parameter int NUM_SW          = 4,
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic                 QClk,
  input  logic                 RstQnnnH,
  board_io_ctrl_if.slave       bus,
  input  logic [NUM_SW-1:0]    Sw,
  input  logic [NUM_BTN-1:0]   Btn,
  output logic [7*NUM_HEX-1:0] Hex,
  output logic [NUM_LED-1:0]   Led
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int BL_W = $clog2(BLINK_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {
    REG_HEX_VAL   = 3'd0,
    REG_HEX_EN    = 3'd1,
    REG_LED       = 3'd2,
    REG_SW        = 3'd3,
    REG_BTN_LVL   = 3'd4,
    REG_BTN_PRESS = 3'd5,
    REG_LED_BLINK = 3'd6,
    REG_NONE      = 3'd7
  } reg_e;

  reg_e                 word;
  logic [4*NUM_HEX-1:0] hex_val;
  logic [NUM_HEX-1:0]   hex_en;
  logic [NUM_LED-1:0]   led_reg;
  logic [NUM_LED-1:0]   led_blink;
  logic [NUM_SW-1:0]    sw_meta, sw_sync;
  logic [NUM_BTN-1:0]   btn_meta, btn_sync, pressed_now;
  logic [NUM_BTN-1:0]   btn_lvl, btn_press, db_flip, press_set, press_clr;
  logic [DB_W-1:0]      db_cnt [NUM_BTN];
  logic [BL_W-1:0]      blink_cnt;
  logic                 blink_phase;
  logic [31:0]          rd_next;
  logic                 unused_bits;

  assign word        = reg_e'(bus.Addr[4:2]);
  assign unused_bits = ^{bus.Addr[1:0], bus.WrData};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      hex_val   <= '0;
      hex_en    <= '0;
      led_reg   <= '0;
      led_blink <= '0;
    end else if (bus.WrEn) begin
      case (word)
        REG_HEX_VAL:   hex_val   <= bus.WrData[4*NUM_HEX-1:0];
        REG_HEX_EN:    hex_en    <= bus.WrData[NUM_HEX-1:0];
        REG_LED:       led_reg   <= bus.WrData[NUM_LED-1:0];
        REG_LED_BLINK: led_blink <= bus.WrData[NUM_LED-1:0];
        default: ;
      endcase
    end
  end

  // Two-flop synchronisers; buttons idle high (released).
  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '1;
      btn_sync <= '1;
    end else begin
      sw_meta  <= Sw;
      sw_sync  <= sw_meta;
      btn_meta <= Btn;
      btn_sync <= btn_meta;
    end
  end

  assign pressed_now = ~btn_sync;

  // NOTE: combinational blocks assign a default before any branch so no latch is inferred.
  always_comb begin
    db_flip = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_flip[i] = (pressed_now[i] != btn_lvl[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  // NOTE: the per-button counter array is small and must restart cleanly, so it is reset.
  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      btn_lvl <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      btn_lvl <= btn_lvl ^ db_flip;
      for (int i = 0; i < NUM_BTN; i++) begin
        if ((pressed_now[i] == btn_lvl[i]) || db_flip[i]) db_cnt[i] <= '0;
        else                                              db_cnt[i] <= db_cnt[i] + DB_W'(1);
      end
    end
  end

  // A fresh press outranks a same-cycle write-one-to-clear.
  assign press_set = db_flip & ~btn_lvl;
  assign press_clr = (bus.WrEn && (word == REG_BTN_PRESS)) ? bus.WrData[NUM_BTN-1:0] : '0;

  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) btn_press <= '0;
    else           btn_press <= (btn_press & ~press_clr) | press_set;
  end

  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + BL_W'(1);
    end
  end

  always_comb begin
    rd_next = '0;
    case (word)
      REG_HEX_VAL:   rd_next[4*NUM_HEX-1:0] = hex_val;
      REG_HEX_EN:    rd_next[NUM_HEX-1:0]   = hex_en;
      REG_LED:       rd_next[NUM_LED-1:0]   = led_reg;
      REG_SW:        rd_next[NUM_SW-1:0]    = sw_sync;
      REG_BTN_LVL:   rd_next[NUM_BTN-1:0]   = btn_lvl;
      REG_BTN_PRESS: rd_next[NUM_BTN-1:0]   = btn_press;
      REG_LED_BLINK: rd_next[NUM_LED-1:0]   = led_blink;
      default: ;
    endcase
  end

  // Read data captures pre-write state, so a combined read/write returns the old value.
  always_ff @(posedge QClk or negedge RstQnnnH) begin
    if (!RstQnnnH)     bus.RdData <= '0;
    else if (bus.RdEn) bus.RdData <= rd_next;
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    Hex = '1;
    for (int d = 0; d < NUM_HEX; d++) begin
      Hex[7*d +: 7] = hex_en[d] ? seg7(hex_val[4*d +: 4]) : 7'h7F;
    end
  end

  assign Led = led_reg & ~(led_blink & {NUM_LED{blink_phase}});
endmodule
